seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit is displayed; legal range 16..2^20.
REQ-002 SHALL have port i_clk, input, 1, the only clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_value_lo, input, 7, low pair value (e.g. seconds), unsigned binary.
REQ-005 SHALL have port i_value_hi, input, 7, high pair value (e.g. minutes), unsigned binary.
REQ-006 SHALL have port o_seg, output, 7, active-low segments; bit0=a through bit6=g.
REQ-007 SHALL have port o_an, output, 4, active-low digit enables, one-hot-low.
REQ-008 SHALL have port o_frame, output, 1, one-cycle pulse when a new input sample is taken.

Function
REQ-009 SHALL run prescaler 0..SCAN_DIV-1; terminal count advances digit index 0->1->2->3->0.
REQ-010 SHALL map digit index 0=lo ones, 1=lo tens, 2=hi ones, 3=hi tens.
REQ-011 SHALL register o_an and o_seg; both change exactly one cycle after the index changes, never in different cycles.
REQ-012 SHALL, on terminal count with index 3 (wrap to 0), sample both inputs and pulse o_frame in that same cycle.
REQ-013 SHALL saturate sampled values >99 to 99 before conversion.
REQ-014 SHALL convert each sample with shift-add-3 (double dabble): 1 load cycle + 7 shift cycles, done pulse on cycle 8 after start.
REQ-015 SHALL update both display digit pairs atomically in the cycle after done; no torn hi/lo mix visible.
REQ-016 SHALL show new digits on o_seg no later than 10 cycles after o_frame.
REQ-017 SHALL ignore input changes between samples; inputs need no synchronisation beyond same-clock domain.
REQ-018 SHALL decode 0-9 to standard patterns: 0=0x40, 1=0x79, 3=0x30, 5=0x12, 7=0x78, 9=0x10; codes 10-15 unreachable, decode to 0x7F.

Reset
REQ-019 SHALL, while i_reset_n low: o_seg=0x7F, o_an=4'b1111, o_frame=0, prescaler=0, index=0, display digits=0, converters idle.
REQ-020 SHALL, after release, issue first sample at the first index-3 wrap, i.e. 4*SCAN_DIV cycles after release; digits display 0 until then.
REQ-021 SHALL abort any in-flight conversion on reset assertion without updating display digits.

Configuration
REQ-022 SHALL support macro SEG7_LZB_EN: defined -> hi tens digit drives o_seg=0x7F when zero (anode still cycled); undefined -> shown as 0x40.
REQ-023 SHALL not alter timing, ports or lo digits with or without SEG7_LZB_EN.

Structure
REQ-024 SHALL place the segment pattern constants, the blank pattern 0x7F, digit index enumeration and saturation limit 99 in shared package seg7_pkg.
REQ-025 SHALL implement conversion as sub-module bin2bcd_seq (i_clk, i_reset_n, i_start, i_bin[6:0], o_done, o_tens[3:0], o_ones[3:0]), instantiated twice.
REQ-026 SHALL ignore i_start in bin2bcd_seq while busy; with SCAN_DIV>=16 this never occurs.

Verification (SCAN_DIV=16)
REQ-027 SHALL verify reset: i_reset_n low mid-scan -> o_seg=0x7F, o_an=4'b1111 same cycle, no o_frame.
REQ-028 SHALL verify sample: lo=37, hi=59, wait for o_frame -> within 10 cycles digits 7,3,9,5 appear on o_an=1110,1101,1011,0111 as 0x78,0x30,0x10,0x12.
REQ-029 SHALL verify saturation: lo=127, hi=100 -> all four digits show 9 (0x10).
REQ-030 SHALL verify atomicity: change lo 12->34 and hi 56->78 one cycle after o_frame -> old 12/56 held a full frame, then 34/78 together.
REQ-031 SHALL verify SEG7_LZB_EN: hi=5, lo=0 -> with macro digit 3 shows 0x7F; without it shows 0x40; index timing identical.
REQ-032 SHALL verify scan timing: each o_an value held exactly 16 cycles; sequence repeats every 64 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment driver.
// Segment patterns are active-low, bit0 = a through bit6 = g.
`timescale 1ns/1ps
package seg7_pkg;

  typedef enum logic [1:0] {
    DIG_LO_ONES = 2'd0,
    DIG_LO_TENS = 2'd1,
    DIG_HI_ONES = 2'd2,
    DIG_HI_TENS = 2'd3
  } dig_idx_e;

  typedef enum logic {
    CV_IDLE  = 1'b0,
    CV_SHIFT = 1'b1
  } conv_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t hi;
    bcd_pair_t lo;
  } disp_t;

  localparam logic [6:0] SAT_LIMIT = 7'd99;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  function automatic logic [6:0] sat99(
    input logic [6:0] v
  );
    return (v > SAT_LIMIT) ? SAT_LIMIT : v;
  endfunction

  function automatic logic [6:0] seg_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] an_of(
    input dig_idx_e idx
  );
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential 7-bit binary to 2-digit BCD converter (shift-add-3).
// One load cycle, seven shift cycles, o_done pulses on the eighth.
`timescale 1ns/1ps
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [6:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  conv_state_e state_q, state_d;
  logic [6:0]  bin_q, bin_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [7:0]  adj;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= CV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    adj     = bcd_q;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    unique case (state_q)
      CV_IDLE: begin
        if (i_start) begin
          bin_d   = i_bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        // start is ignored here: a busy converter finishes first
        bcd_d = {adj[6:0], bin_q[6]};
        bin_d = {bin_q[5:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          state_d = CV_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = CV_IDLE;
    endcase
  end

  assign o_done = done_q;
  assign o_tens = bcd_q[7:4];
  assign o_ones = bcd_q[3:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver for two 0..99 values.
// Build option SEG7_LZB_EN blanks the high tens digit when it is zero.
`timescale 1ns/1ps
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [6:0] i_value_lo,
  input  logic [6:0] i_value_hi,
  output logic [6:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_frame
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  dig_idx_e      idx_q, idx_d;
  disp_t         disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tc;
  logic          frame;
  logic [3:0]    digit;
  logic          lz;

  logic       lo_done, hi_done;
  logic [3:0] lo_tens, lo_ones;
  logic [3:0] hi_tens, hi_ones;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      idx_q  <= DIG_LO_ONES;
      disp_q <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  always_comb begin
    tc    = (cnt_q == TC);
    frame = tc && (idx_q == DIG_HI_TENS);
    cnt_d = tc ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tc) idx_d = dig_idx_e'(2'(idx_q) + 2'd1);
  end

  bin2bcd_seq u_conv_lo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (frame),
    .i_bin     (sat99(i_value_lo)),
    .o_done    (lo_done),
    .o_tens    (lo_tens),
    .o_ones    (lo_ones)
  );

  bin2bcd_seq u_conv_hi (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (frame),
    .i_bin     (sat99(i_value_hi)),
    .o_done    (hi_done),
    .o_tens    (hi_tens),
    .o_ones    (hi_ones)
  );

  // both pairs commit together so a scan never shows a hi/lo mix
  always_comb begin
    disp_d = disp_q;
    if (lo_done && hi_done) begin
      disp_d.lo.tens = lo_tens;
      disp_d.lo.ones = lo_ones;
      disp_d.hi.tens = hi_tens;
      disp_d.hi.ones = hi_ones;
    end
  end

  always_comb begin
    digit = disp_q.lo.ones;
    lz    = 1'b0;
    unique case (idx_q)
      DIG_LO_ONES: digit = disp_q.lo.ones;
      DIG_LO_TENS: digit = disp_q.lo.tens;
      DIG_HI_ONES: digit = disp_q.hi.ones;
      DIG_HI_TENS: digit = disp_q.hi.tens;
      default:     digit = disp_q.lo.ones;
    endcase
`ifdef SEG7_LZB_EN
    lz = (idx_q == DIG_HI_TENS) && (digit == 4'd0);
`else
    lz = 1'b0;
`endif
    seg_d = lz ? SEG_BLANK : seg_decode(digit);
    an_d  = an_of(idx_q);
  end

  assign o_seg   = seg_q;
  assign o_an    = an_q;
  assign o_frame = frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=16.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int DIV   = 16;
  localparam int N     = 12;
  localparam int NDIR  = 6;
  localparam int RST_K = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] lo, hi;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_value_lo (lo),
    .i_value_hi (hi),
    .o_seg      (seg),
    .o_an       (an),
    .o_frame    (frame)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  int   cyc = 0;
  int   plan_lo[N];
  int   plan_hi[N];

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // expected content of the four scan slots following a sample
  function automatic void push_frame(input int l, input int h);
    int   d[4];
    exp_t e;
    l = sat(l);
    h = sat(h);
    d[0] = l % 10;
    d[1] = l / 10;
    d[2] = h % 10;
    d[3] = h / 10;
    for (int i = 0; i < 4; i++) begin
      e.an  = 4'(~(4'b0001 << i));
      e.seg = pat(d[i]);
`ifdef SEG7_LZB_EN
      if (i == 3 && d[3] == 0) e.seg = 7'h7F;
`endif
      q.push_back(e);
    end
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_seg"}, 32'(seg), 32'h7F);
    check({name, "_an"}, 32'(an), 32'hF);
    check({name, "_frame"}, 32'(frame), 32'h0);
  endtask

  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout actual=none required=pulse_in_200");
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else cyc++;
  end

  logic [3:0] prev_an = 4'hF;
  logic [6:0] prev_seg = 7'h7F;
  int         len = 0;

  always @(negedge clk) begin
    exp_t e;
    if (an !== prev_an) begin
      if (mon_en && prev_an !== 4'hF && an !== 4'hF) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=slot_end required=none");
        end else begin
          e = q.pop_front();
          check("slot_an", 32'(prev_an), 32'(e.an));
          check("slot_seg", 32'(prev_seg), 32'(e.seg));
          check("slot_len", 32'(len), 32'(DIV));
        end
      end
      len = 1;
    end else begin
      len++;
    end
    prev_an  = an;
    prev_seg = seg;
  end

  initial begin
    int dl[NDIR];
    int dh[NDIR];
    bit ok;
    int n;
    dl = '{37, 127, 12, 34, 0, 99};
    dh = '{59, 100, 56, 78, 5, 0};
    for (int k = 0; k < N; k++) begin
      if (k < NDIR) begin
        plan_lo[k] = dl[k];
        plan_hi[k] = dh[k];
      end else begin
        plan_lo[k] = int'($urandom_range(0, 127));
        plan_hi[k] = int'($urandom_range(0, 127));
      end
    end

    rst_n = 1'b0;
    lo = '0;
    hi = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (37) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    repeat (4) @(posedge clk);
    q.delete();
    push_frame(0, 0);
    mon_en = 1;
    lo = 7'(plan_lo[0]);
    hi = 7'(plan_hi[0]);
    #2 rst_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      wait_frame(ok);
      if (!ok) break;
      check("frame_pos", 32'(cyc % 64), 32'd63);
      if (k == RST_K) begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_conv");
        repeat (3) @(posedge clk);
        q.delete();
        push_frame(0, 0);
        lo = 7'(plan_lo[k+1]);
        hi = 7'(plan_hi[k+1]);
        #2 rst_n = 1'b1;
        continue;
      end
      push_frame(plan_lo[k], plan_hi[k]);
      @(posedge clk);
      #1;
      if (k + 1 < N) begin
        lo = 7'(plan_lo[k+1]);
        hi = 7'(plan_hi[k+1]);
      end
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("f10_an", 32'(an), 32'hE);
      check("f10_seg", 32'(seg), 32'(pat(sat(plan_lo[k]) % 10)));
      if (k >= NDIR && k + 1 < N) begin
        n = int'($urandom_range(1, 30));
        repeat (n) begin
          @(posedge clk);
          #1;
          lo = 7'($urandom);
          hi = 7'($urandom);
        end
        lo = 7'(plan_lo[k+1]);
        hi = 7'(plan_hi[k+1]);
      end
    end

    wait_frame(ok);
    repeat (3) @(negedge clk);
    mon_en = 0;
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
